dispatch_ctrl: RTL and testbench

Parametrised, buffered dispatch stage between rename/register-read and the four issue queues (int, mult, div, ld_st). Instructions are decoded and routed at enqueue into a DEPTH-entry in-order buffer. The head entry is dispatched only when its target queue is not full. Waiting operands snoop the CDB, and the block adds branch-stall sequencing, flush, illegal-opcode detection and a stall counter.

---
 rtl/dispatch_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 tb/tb_dispatch_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: buffered dispatch stage between rename/register-read and four issue queues.
// Instructions are decoded and routed at enqueue into a DEPTH-entry in-order buffer; the head
// is written into its target queue when that queue has room.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid / in_ready            enqueue handshake (in_ready = count < DEPTH)
//   in_opcode/func3/func7, in_rs1/rs2/rd, in_rs*_data/valid/tag, in_rd_tag, in_imm
//                                  decoded instruction and operands
//   cdb_valid, cdb_tag, cdb_data   common data bus, snooped by waiting operands
//   flush, branch_resolved         control pulses
//   *_full                         issue-queue full flags
//   *_dispatch_en                  one-hot write pulses toward the issue queues
//   out_*                          head entry fields (zero while empty)
//   illegal_op                     registered pulse for an unsupported opcode
//   stall_cnt                      saturating count of cycles the head was held
module dispatch_ctrl #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned MULDIV_EN = 1,
    parameter int unsigned BR_STALL  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_func3,
    input  logic [6:0]        in_func7,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic [DATA_W-1:0] in_rs1_data,
    input  logic [DATA_W-1:0] in_rs2_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_rs1_valid,
    input  logic              in_rs2_valid,
    input  logic [TAG_W-1:0]  in_rs1_tag,
    input  logic [TAG_W-1:0]  in_rs2_tag,
    input  logic [TAG_W-1:0]  in_rd_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              flush,
    input  logic              branch_resolved,
    input  logic              int_full,
    input  logic              mult_full,
    input  logic              div_full,
    input  logic              ld_st_full,
    output logic              int_dispatch_en,
    output logic              mult_dispatch_en,
    output logic              div_dispatch_en,
    output logic              ld_st_dispatch_en,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_func3,
    output logic [6:0]        out_func7,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_rs1_data,
    output logic              out_rs1_valid,
    output logic [TAG_W-1:0]  out_rs1_tag,
    output logic [DATA_W-1:0] out_rs2_data,
    output logic              out_rs2_valid,
    output logic [TAG_W-1:0]  out_rs2_tag,
    output logic [TAG_W-1:0]  out_rd_tag,
    output logic              out_ld_st_opcode,
    output logic              out_wb_valid,
    output logic              illegal_op,
    output logic [15:0]       stall_cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    typedef enum logic [1:0] {TgtInt, TgtMult, TgtDiv, TgtLdSt} tgt_e;
    typedef enum logic [0:0] {StRun, StBrWait} state_e;

    typedef struct packed {
        tgt_e              tgt;
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] rs1_data;
        logic              rs1_valid;
        logic [TAG_W-1:0]  rs1_tag;
        logic [DATA_W-1:0] rs2_data;
        logic              rs2_valid;
        logic [TAG_W-1:0]  rs2_tag;
        logic [TAG_W-1:0]  rd_tag;
        logic              ld_st;
        logic              wb_valid;
    } entry_t;

    entry_t          entry_q [DEPTH];
    entry_t          entry_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    logic            illegal_q;
    logic [15:0]     stall_q;

    tgt_e   dec_tgt;
    logic   dec_store, dec_illegal;
    entry_t new_entry, head, head_fwd;
    logic   accept, push, pop, head_valid, tgt_full;

    assign in_ready   = (count_q < CntW'(DEPTH));
    assign accept     = in_valid && in_ready && !flush;
    assign push       = accept && dec_store;
    assign head_valid = (count_q != '0);
    assign head       = entry_q[rd_ptr_q];

    // Route decode; JAL is consumed without occupying a slot.
    always_comb begin
        dec_tgt     = TgtInt;
        dec_store   = 1'b0;
        dec_illegal = 1'b0;
        case (in_opcode)
            OpRType: begin
                if (in_func7 == 7'd1) begin
                    if (MULDIV_EN == 0) begin
                        dec_illegal = 1'b1;
                    end else begin
                        dec_store = 1'b1;
                        dec_tgt   = in_func3[2] ? TgtDiv : TgtMult;
                    end
                end else begin
                    dec_store = 1'b1;
                end
            end
            OpIType, OpBranch, OpJalr, OpLui, OpAuipc: dec_store = 1'b1;
            OpLoad, OpStore: begin
                dec_store = 1'b1;
                dec_tgt   = TgtLdSt;
            end
            OpJal:   dec_store = 1'b0;
            default: dec_illegal = 1'b1;
        endcase
    end

    // Operand capture, including a same-cycle CDB bypass for operands still in flight.
    always_comb begin
        new_entry          = '0;
        new_entry.tgt      = dec_tgt;
        new_entry.opcode   = in_opcode;
        new_entry.func3    = in_func3;
        new_entry.func7    = in_func7;
        new_entry.imm      = in_imm;
        new_entry.rs1_tag  = in_rs1_tag;
        new_entry.rs2_tag  = in_rs2_tag;
        new_entry.rd_tag   = in_rd_tag;
        new_entry.ld_st    = (in_opcode == OpStore);

        if (in_rs1 == 5'd0) begin
            new_entry.rs1_data  = '0;
            new_entry.rs1_valid = 1'b1;
        end else if (in_rs1_valid) begin
            new_entry.rs1_data  = in_rs1_data;
            new_entry.rs1_valid = 1'b1;
        end else if (cdb_valid && (cdb_tag == in_rs1_tag)) begin
            new_entry.rs1_data  = cdb_data;
            new_entry.rs1_valid = 1'b1;
        end else begin
            new_entry.rs1_data  = in_rs1_data;
            new_entry.rs1_valid = 1'b0;
        end

        if ((in_opcode == OpIType) || (in_opcode == OpLui)) begin
            new_entry.rs2_data  = in_imm;
            new_entry.rs2_valid = 1'b1;
        end else if (in_opcode == OpLoad) begin
            new_entry.rs2_data  = in_rs2_data;
            new_entry.rs2_valid = 1'b1;
        end else if (in_rs2 == 5'd0) begin
            new_entry.rs2_data  = '0;
            new_entry.rs2_valid = 1'b1;
        end else if (in_rs2_valid) begin
            new_entry.rs2_data  = in_rs2_data;
            new_entry.rs2_valid = 1'b1;
        end else if (cdb_valid && (cdb_tag == in_rs2_tag)) begin
            new_entry.rs2_data  = cdb_data;
            new_entry.rs2_valid = 1'b1;
        end else begin
            new_entry.rs2_data  = in_rs2_data;
            new_entry.rs2_valid = 1'b0;
        end

        case (in_opcode)
            OpRType, OpIType, OpLoad, OpLui, OpAuipc, OpJalr: new_entry.wb_valid = (in_rd != 5'd0);
            default:                                          new_entry.wb_valid = 1'b0;
        endcase
    end

    // Head view with same-cycle CDB forwarding, zeroed while the buffer is empty.
    always_comb begin
        head_fwd = head;
        if (cdb_valid && !head.rs1_valid && (head.rs1_tag == cdb_tag)) begin
            head_fwd.rs1_data  = cdb_data;
            head_fwd.rs1_valid = 1'b1;
        end
        if (cdb_valid && !head.rs2_valid && (head.rs2_tag == cdb_tag)) begin
            head_fwd.rs2_data  = cdb_data;
            head_fwd.rs2_valid = 1'b1;
        end
        if (!head_valid) begin
            head_fwd = '0;
        end
    end

    assign out_opcode       = head_fwd.opcode;
    assign out_func3        = head_fwd.func3;
    assign out_func7        = head_fwd.func7;
    assign out_imm          = head_fwd.imm;
    assign out_rs1_data     = head_fwd.rs1_data;
    assign out_rs1_valid    = head_fwd.rs1_valid;
    assign out_rs1_tag      = head_fwd.rs1_tag;
    assign out_rs2_data     = head_fwd.rs2_data;
    assign out_rs2_valid    = head_fwd.rs2_valid;
    assign out_rs2_tag      = head_fwd.rs2_tag;
    assign out_rd_tag       = head_fwd.rd_tag;
    assign out_ld_st_opcode = head_fwd.ld_st;
    assign out_wb_valid     = head_fwd.wb_valid;
    assign illegal_op       = illegal_q;
    assign stall_cnt        = stall_q;

    always_comb begin
        unique case (head.tgt)
            TgtInt:  tgt_full = int_full;
            TgtMult: tgt_full = mult_full;
            TgtDiv:  tgt_full = div_full;
            TgtLdSt: tgt_full = ld_st_full;
        endcase
    end

    assign pop = head_valid && !tgt_full && (state_q == StRun) && !flush;

    always_comb begin
        int_dispatch_en   = 1'b0;
        mult_dispatch_en  = 1'b0;
        div_dispatch_en   = 1'b0;
        ld_st_dispatch_en = 1'b0;
        if (pop) begin
            unique case (head.tgt)
                TgtInt:  int_dispatch_en   = 1'b1;
                TgtMult: mult_dispatch_en  = 1'b1;
                TgtDiv:  div_dispatch_en   = 1'b1;
                TgtLdSt: ld_st_dispatch_en = 1'b1;
            endcase
        end
    end

    // CDB snoop on stored entries; the slot being written takes the fresh entry instead.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
            if (cdb_valid && !entry_q[i].rs1_valid && (entry_q[i].rs1_tag == cdb_tag)) begin
                entry_d[i].rs1_data  = cdb_data;
                entry_d[i].rs1_valid = 1'b1;
            end
            if (cdb_valid && !entry_q[i].rs2_valid && (entry_q[i].rs2_tag == cdb_tag)) begin
                entry_d[i].rs2_data  = cdb_data;
                entry_d[i].rs2_valid = 1'b1;
            end
            if (push && (wr_ptr_q == PtrW'(i))) begin
                entry_d[i] = new_entry;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (pop && (BR_STALL != 0) &&
                        ((head.opcode == OpBranch) || (head.opcode == OpJalr))) begin
                        state_d = StBrWait;
                    end
                end
                StBrWait: begin
                    if (branch_resolved) begin
                        state_d = StRun;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= StRun;
            illegal_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            entry_q   <= entry_d;
            count_q   <= count_d;
            state_q   <= state_d;
            illegal_q <= accept && dec_illegal;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (head_valid && !pop && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid, in_rs1_valid, in_rs2_valid;
    logic [6:0]  in_opcode, in_func7;
    logic [2:0]  in_func3;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, cdb_data;
    logic [5:0]  in_rs1_tag, in_rs2_tag, in_rd_tag, cdb_tag;
    logic        cdb_valid, flush, branch_resolved;
    logic        int_full, mult_full, div_full, ld_st_full;

    logic        in_ready, int_en, mult_en, div_en, ld_st_en;
    logic [6:0]  out_opcode, out_func7;
    logic [2:0]  out_func3;
    logic [31:0] out_imm, out_rs1_data, out_rs2_data;
    logic        out_rs1_valid, out_rs2_valid, out_ld_st_opcode, out_wb_valid, illegal_op;
    logic [5:0]  out_rs1_tag, out_rs2_tag, out_rd_tag;
    logic [15:0] stall_cnt;

    // Second instance with the multiply/divide extension disabled.
    logic        m0_in_ready, m0_int_en, m0_mult_en, m0_div_en, m0_ld_st_en;
    logic [6:0]  m0_opcode, m0_func7;
    logic [2:0]  m0_func3;
    logic [31:0] m0_imm, m0_rs1_data, m0_rs2_data;
    logic        m0_rs1_valid, m0_rs2_valid, m0_ld_st_opcode, m0_wb_valid, m0_illegal_op;
    logic [5:0]  m0_rs1_tag, m0_rs2_tag, m0_rd_tag;
    logic [15:0] m0_stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dispatch_ctrl #(.DATA_W(32), .TAG_W(6), .DEPTH(2), .MULDIV_EN(1), .BR_STALL(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_valid(in_rs1_valid), .in_rs2_valid(in_rs2_valid),
        .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag), .in_rd_tag(in_rd_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush), .branch_resolved(branch_resolved),
        .int_full(int_full), .mult_full(mult_full), .div_full(div_full),
        .ld_st_full(ld_st_full),
        .int_dispatch_en(int_en), .mult_dispatch_en(mult_en), .div_dispatch_en(div_en),
        .ld_st_dispatch_en(ld_st_en),
        .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
        .out_imm(out_imm), .out_rs1_data(out_rs1_data), .out_rs1_valid(out_rs1_valid),
        .out_rs1_tag(out_rs1_tag), .out_rs2_data(out_rs2_data),
        .out_rs2_valid(out_rs2_valid), .out_rs2_tag(out_rs2_tag), .out_rd_tag(out_rd_tag),
        .out_ld_st_opcode(out_ld_st_opcode), .out_wb_valid(out_wb_valid),
        .illegal_op(illegal_op), .stall_cnt(stall_cnt)
    );

    dispatch_ctrl #(.DATA_W(32), .TAG_W(6), .DEPTH(2), .MULDIV_EN(0), .BR_STALL(1)) u_m0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m0_in_ready),
        .in_opcode(in_opcode), .in_func3(in_func3), .in_func7(in_func7),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1_valid(in_rs1_valid), .in_rs2_valid(in_rs2_valid),
        .in_rs1_tag(in_rs1_tag), .in_rs2_tag(in_rs2_tag), .in_rd_tag(in_rd_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .flush(flush), .branch_resolved(branch_resolved),
        .int_full(int_full), .mult_full(mult_full), .div_full(div_full),
        .ld_st_full(ld_st_full),
        .int_dispatch_en(m0_int_en), .mult_dispatch_en(m0_mult_en),
        .div_dispatch_en(m0_div_en), .ld_st_dispatch_en(m0_ld_st_en),
        .out_opcode(m0_opcode), .out_func3(m0_func3), .out_func7(m0_func7),
        .out_imm(m0_imm), .out_rs1_data(m0_rs1_data), .out_rs1_valid(m0_rs1_valid),
        .out_rs1_tag(m0_rs1_tag), .out_rs2_data(m0_rs2_data),
        .out_rs2_valid(m0_rs2_valid), .out_rs2_tag(m0_rs2_tag), .out_rd_tag(m0_rd_tag),
        .out_ld_st_opcode(m0_ld_st_opcode), .out_wb_valid(m0_wb_valid),
        .illegal_op(m0_illegal_op), .stall_cnt(m0_stall_cnt)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1, rs2, rd;
        logic        v1, v2;
        logic [31:0] d1, d2, imm;
        logic [3:0]  en;      // {int, mult, div, ld_st}
        logic [31:0] e_d1;
        logic        e_v1;
        logic [31:0] e_d2;
        logic        e_v2;
        logic        e_wb, e_st, e_ill, e_ill0;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_opcode = 0; in_func3 = 0; in_func7 = 0;
        in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
        in_rs1_valid = 0; in_rs2_valid = 0;
        in_rs1_tag = 6'd1; in_rs2_tag = 6'd2; in_rd_tag = 6'd3;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        flush = 0; branch_resolved = 0;
        int_full = 0; mult_full = 0; div_full = 0; ld_st_full = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic v1, input logic v2, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm);
        in_valid = 1; in_opcode = op; in_func3 = f3; in_func7 = f7;
        in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_rs1_valid = v1; in_rs2_valid = v2;
        in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
    endtask

    function automatic logic [3:0] en_vec();
        return {int_en, mult_en, div_en, ld_st_en};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          op     f3    f7     rs1   rs2   rd    v1 v2 d1      d2      imm
        //          en       e_d1          e_v1 e_d2          e_v2 wb st ill ill0
        vecs[0]  = '{7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 1, 1, 32'd10, 32'd20, 32'd0,
                     4'b1000, 32'd10, 1, 32'd20, 1, 1, 0, 0, 0};             // ADD x3,x1,x2
        vecs[1]  = '{7'h13, 3'd0, 7'h00, 5'd0, 5'd5, 5'd0, 0, 0, 32'h77, 32'h88, 32'd5,
                     4'b1000, 32'd0, 1, 32'd5, 1, 0, 0, 0, 0};               // ADDI x0,x0,5
        vecs[2]  = '{7'h33, 3'd0, 7'h01, 5'd1, 5'd2, 5'd4, 1, 1, 32'd3, 32'd7, 32'd0,
                     4'b0100, 32'd3, 1, 32'd7, 1, 1, 0, 0, 1};               // MUL
        vecs[3]  = '{7'h33, 3'd4, 7'h01, 5'd1, 5'd2, 5'd4, 1, 1, 32'd3, 32'd7, 32'd0,
                     4'b0010, 32'd3, 1, 32'd7, 1, 1, 0, 0, 1};               // DIV
        vecs[4]  = '{7'h23, 3'd2, 7'h00, 5'd1, 5'd2, 5'd0, 1, 1, 32'h100, 32'h55, 32'd8,
                     4'b0001, 32'h100, 1, 32'h55, 1, 0, 1, 0, 0};            // SW
        vecs[5]  = '{7'h03, 3'd2, 7'h00, 5'd1, 5'd9, 5'd5, 1, 0, 32'h200, 32'h66, 32'd4,
                     4'b0001, 32'h200, 1, 32'h66, 1, 1, 0, 0, 0};            // LW
        vecs[6]  = '{7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd7, 1, 1, 32'd1, 32'd2, 32'd16,
                     4'b1000, 32'd1, 1, 32'd2, 1, 0, 0, 0, 0};               // BEQ
        vecs[7]  = '{7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 1, 1, 32'd1, 32'd2, 32'd64,
                     4'b0000, 32'd0, 0, 32'd0, 0, 0, 0, 0, 0};               // JAL
        vecs[8]  = '{7'h7F, 3'd0, 7'h00, 5'd1, 5'd2, 5'd1, 1, 1, 32'd1, 32'd2, 32'd0,
                     4'b0000, 32'd0, 0, 32'd0, 0, 0, 0, 1, 1};               // bad opcode
        vecs[9]  = '{7'h37, 3'd0, 7'h00, 5'd0, 5'd0, 5'd6, 0, 0, 32'd9, 32'd9, 32'hABCD000,
                     4'b1000, 32'd0, 1, 32'hABCD000, 1, 1, 0, 0, 0};         // LUI
        vecs[10] = '{7'h33, 3'd0, 7'h20, 5'd1, 5'd3, 5'd8, 1, 0, 32'd40, 32'h99, 32'd0,
                     4'b1000, 32'd40, 1, 32'h99, 0, 1, 0, 0, 0};             // SUB, rs2 pending
        vecs[11] = '{7'h17, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 0, 0, 32'd5, 32'd6, 32'h1000,
                     4'b1000, 32'd0, 1, 32'd0, 1, 0, 0, 0, 0};               // AUIPC x0
        vecs[12] = '{7'h67, 3'd0, 7'h00, 5'd1, 5'd0, 5'd1, 1, 0, 32'h40, 32'd3, 32'd4,
                     4'b1000, 32'h40, 1, 32'd0, 1, 1, 0, 0, 0};              // JALR

        do_reset();
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_en", en_vec(), 0);
        chk("rst_illegal", illegal_op, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_opcode", out_opcode, 0);
        chk("rst_rs1_valid", out_rs1_valid, 0);

        // Single-instruction table: enqueue, inspect head, let it drain, release any branch.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].v1, vecs[i].v2, vecs[i].d1, vecs[i].d2, vecs[i].imm);
            @(negedge clk);
            in_valid = 0;
            #1;
            chk($sformatf("v%0d_en", i), en_vec(), vecs[i].en);
            chk($sformatf("v%0d_opcode", i), out_opcode, (vecs[i].en != 0) ? vecs[i].op : 7'd0);
            chk($sformatf("v%0d_rs1_data", i), out_rs1_data, vecs[i].e_d1);
            chk($sformatf("v%0d_rs1_valid", i), out_rs1_valid, vecs[i].e_v1);
            chk($sformatf("v%0d_rs2_data", i), out_rs2_data, vecs[i].e_d2);
            chk($sformatf("v%0d_rs2_valid", i), out_rs2_valid, vecs[i].e_v2);
            chk($sformatf("v%0d_wb", i), out_wb_valid, vecs[i].e_wb);
            chk($sformatf("v%0d_st", i), out_ld_st_opcode, vecs[i].e_st);
            chk($sformatf("v%0d_illegal", i), illegal_op, vecs[i].e_ill);
            chk($sformatf("v%0d_m0_illegal", i), m0_illegal_op, vecs[i].e_ill0);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_drained", i), en_vec(), 0);
            chk($sformatf("v%0d_ill_pulse", i), illegal_op, 0);
            branch_resolved = 1;
            @(negedge clk);
            branch_resolved = 0;
        end
        chk("table_stall", stall_cnt, 0);

        // MUL held by a full multiply queue for three cycles.
        do_reset();
        mult_full = 1;
        @(negedge clk);
        drive(7'h33, 3'd0, 7'h01, 5'd1, 5'd2, 5'd4, 1, 1, 32'd6, 32'd7, 32'd0);
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("mul_m0_illegal", m0_illegal_op, 1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("mul_hold%0d", k), mult_en, 0);
            chk($sformatf("mul_stall%0d", k), stall_cnt, k);
            @(negedge clk);
        end
        mult_full = 0;
        #1;
        chk("mul_stall3", stall_cnt, 3);
        chk("mul_dispatch", en_vec(), 4'b0100);
        chk("mul_m0_en", {m0_int_en, m0_mult_en, m0_div_en, m0_ld_st_en}, 0);
        chk("mul_m0_illegal_off", m0_illegal_op, 0);
        @(negedge clk);
        #1;
        chk("mul_after", mult_en, 0);
        chk("mul_stall_keep", stall_cnt, 3);

        // LW with rs1 woken by the CDB in the enqueue cycle, then in a later cycle.
        do_reset();
        ld_st_full = 1;
        @(negedge clk);
        drive(7'h03, 3'd2, 7'h00, 5'd1, 5'd0, 5'd5, 0, 0, 32'hDEAD, 32'd0, 32'd0);
        in_rs1_tag = 6'd5;
        cdb_valid = 1; cdb_tag = 6'd5; cdb_data = 32'h1234;
        @(negedge clk);
        in_valid = 0; cdb_valid = 0;
        #1;
        chk("byp_rs1_data", out_rs1_data, 32'h1234);
        chk("byp_rs1_valid", out_rs1_valid, 1);
        ld_st_full = 0;
        #1;
        chk("byp_dispatch", en_vec(), 4'b0001);
        @(negedge clk);
        ld_st_full = 1;
        drive(7'h03, 3'd2, 7'h00, 5'd1, 5'd0, 5'd5, 0, 0, 32'h9999, 32'd0, 32'd0);
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("snoop_pending", out_rs1_valid, 0);
        cdb_valid = 1; cdb_tag = 6'd6; cdb_data = 32'h4321;
        #1;
        chk("snoop_wrong_tag", out_rs1_valid, 0);
        cdb_tag = 6'd5; cdb_data = 32'h1234;
        #1;
        chk("fwd_rs1_data", out_rs1_data, 32'h1234);
        chk("fwd_rs1_valid", out_rs1_valid, 1);
        @(negedge clk);
        cdb_valid = 0;
        #1;
        chk("snoop_rs1_data", out_rs1_data, 32'h1234);
        chk("snoop_rs1_valid", out_rs1_valid, 1);
        ld_st_full = 0;
        @(negedge clk);

        // BEQ then ADDI: ADDI waits for branch_resolved.
        do_reset();
        @(negedge clk);
        drive(7'h63, 3'd0, 7'h00, 5'd1, 5'd2, 5'd0, 1, 1, 32'd1, 32'd1, 32'd8);
        @(negedge clk);
        drive(7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 0, 0, 32'd0, 32'd0, 32'd1);
        #1;
        chk("br_beq_en", int_en, 1);
        chk("br_beq_op", out_opcode, 7'h63);
        @(negedge clk);
        in_valid = 0;
        #1;
        chk("br_wait0", int_en, 0);
        chk("br_addi_head", out_opcode, 7'h13);
        chk("br_stall0", stall_cnt, 0);
        @(negedge clk);
        #1;
        chk("br_wait1", int_en, 0);
        chk("br_stall1", stall_cnt, 1);
        branch_resolved = 1;
        @(negedge clk);
        branch_resolved = 0;
        #1;
        chk("br_addi_en", int_en, 1);
        chk("br_addi_op", out_opcode, 7'h13);
        chk("br_stall2", stall_cnt, 2);
        @(negedge clk);
        #1;
        chk("br_empty", en_vec(), 0);
        chk("br_empty_op", out_opcode, 0);

        // Fill both slots, then flush.
        do_reset();
        ld_st_full = 1;
        @(negedge clk);
        drive(7'h03, 3'd2, 7'h00, 5'd0, 5'd0, 5'd5, 0, 0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        #1;
        chk("fill_ready1", in_ready, 1);
        @(negedge clk);
        #1;
        chk("fill_ready0", in_ready, 0);
        chk("fill_no_en", ld_st_en, 0);
        @(negedge clk);
        flush = 1; ld_st_full = 0;
        #1;
        chk("fill_still_full", in_ready, 0);
        chk("flush_no_en", en_vec(), 0);
        @(negedge clk);
        flush = 0; in_valid = 0;
        #1;
        chk("flush_ready", in_ready, 1);
        chk("flush_empty_op", out_opcode, 0);
        chk("flush_en", en_vec(), 0);

        // Asynchronous reset in the middle of a stalled cycle.
        do_reset();
        int_full = 1;
        @(negedge clk);
        drive(7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 1, 1, 32'd1, 32'd2, 32'd0);
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        #1;
        chk("arst_pre_stall", stall_cnt, 1);
        int_full = 0;
        #1;
        rst_n = 0;
        #1;
        chk("arst_ready", in_ready, 1);
        chk("arst_en", en_vec(), 0);
        chk("arst_stall", stall_cnt, 0);
        chk("arst_op", out_opcode, 0);
        @(negedge clk);
        rst_n = 1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
